// File: rtl/queue_ctrl.sv
// Sequencer for the deserializer word queue: round-robin arbitration
// between producer enqueues and latched consumer reads.
module queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock_10,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid_in,
    output logic             word_ack_out,
    input  logic             rd_req_in,
    output logic [WIDTH-1:0] rd_data_out,
    output logic             rd_valid_out,
    output logic [WIDTH-1:0] q_data_out,
    output logic             q_enq_out,
    output logic             q_deq_out,
    input  logic [WIDTH-1:0] q_data_in,
    input  logic [7:0]       q_len_in,
    output logic             full_out,
    output logic             empty_out,
    output logic             err_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENQ  = 2'd1;
    localparam logic [1:0] S_DEQ  = 2'd2;
    localparam logic [1:0] S_CAPT = 2'd3;

    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             pending;
    logic             last_deq;
    logic             wr_ok;
    logic             rd_ok;
    logic             grant_wr;
    logic [WIDTH-1:0] q_data_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;
    logic             full_r;
    logic             empty_r;
    logic             err_r;

    always_comb begin
        wr_ok    = word_valid_in && (q_len_in < DEPTH_L);
        rd_ok    = (pending || rd_req_in) && (q_len_in != 8'd0);
        // On a tie the side not served last wins.
        grant_wr = wr_ok && (!rd_ok || last_deq);
        state_n  = state;
        unique case (state)
            S_IDLE: begin
                if (grant_wr) begin
                    state_n = S_ENQ;
                end else if (rd_ok) begin
                    state_n = S_DEQ;
                end
            end
            S_ENQ:   state_n = S_IDLE;
            S_DEQ:   state_n = S_CAPT;
            S_CAPT:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_10) begin
        if (reset) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            last_deq   <= 1'b1;
            q_data_r   <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            err_r      <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= rd_req_in || (pending && (state_n != S_DEQ));
            if (state_n == S_ENQ) begin
                last_deq <= 1'b0;
                q_data_r <= word_in;
            end
            if (state_n == S_DEQ) begin
                last_deq <= 1'b1;
            end
            rd_valid_r <= (state == S_CAPT);
            if (state == S_CAPT) begin
                rd_data_r <= q_data_in;
            end
            full_r  <= (q_len_in == DEPTH_L);
            empty_r <= (q_len_in == 8'd0);
            if (q_len_in > DEPTH_L) begin
                err_r <= 1'b1;
            end
        end
    end

    assign q_enq_out    = (state == S_ENQ);
    assign word_ack_out = (state == S_ENQ);
    assign q_deq_out    = (state == S_DEQ);
    assign q_data_out   = q_data_r;
    assign rd_data_out  = rd_data_r;
    assign rd_valid_out = rd_valid_r;
    assign full_out     = full_r;
    assign empty_out    = empty_r;
    assign err_out      = err_r;

endmodule

// File: tb/tb_queue_ctrl.sv
// Bench for queue_ctrl: directed steps plus random traffic against an
// in-order word scoreboard and a behavioural 8-entry queue.
module tb_queue_ctrl;

    logic       clock_10 = 1'b0;
    logic       reset;
    logic [7:0] word_in;
    logic       word_valid_in;
    logic       word_ack_out;
    logic       rd_req_in;
    logic [7:0] rd_data_out;
    logic       rd_valid_out;
    logic [7:0] q_data_out;
    logic       q_enq_out;
    logic       q_deq_out;
    logic [7:0] q_data_in;
    logic [7:0] q_len_in;
    logic       full_out;
    logic       empty_out;
    logic       err_out;

    int checks   = 0;
    int failures = 0;

    always #5 clock_10 = ~clock_10;

    queue_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
        .clock_10      (clock_10),
        .reset         (reset),
        .word_in       (word_in),
        .word_valid_in (word_valid_in),
        .word_ack_out  (word_ack_out),
        .rd_req_in     (rd_req_in),
        .rd_data_out   (rd_data_out),
        .rd_valid_out  (rd_valid_out),
        .q_data_out    (q_data_out),
        .q_enq_out     (q_enq_out),
        .q_deq_out     (q_deq_out),
        .q_data_in     (q_data_in),
        .q_len_in      (q_len_in),
        .full_out      (full_out),
        .empty_out     (empty_out),
        .err_out       (err_out)
    );

    // Behavioural queue: push on enq, pop into data register on deq.
    logic [7:0] mq[$];
    logic [7:0] qlen;
    int         preload_n = 0;
    logic       force_en  = 1'b0;
    logic [7:0] force_val = 8'd0;

    assign q_len_in = force_en ? force_val : qlen;

    always @(posedge clock_10) begin
        if (reset) begin
            mq.delete();
            for (int i = 0; i < preload_n; i++) mq.push_back(8'(8'hE0 + i));
            qlen      <= 8'(preload_n);
            q_data_in <= 8'd0;
        end else begin
            if (q_deq_out && mq.size() > 0) q_data_in <= mq.pop_front();
            if (q_enq_out && mq.size() < 8) mq.push_back(q_data_out);
            qlen <= 8'(mq.size());
        end
    end

    logic [7:0] sb[$];
    logic [7:0] le;
    logic       re;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        chk("full_flag", 32'(full_out), re ? 32'd0 : 32'(le == 8'd8));
        chk("empty_flag", 32'(empty_out), re ? 32'd1 : 32'(le == 8'd0));
        chk("ack_vs_enq", 32'(word_ack_out), 32'(q_enq_out));
        if (q_enq_out) chk("enq_at_full", 32'(q_len_in >= 8'd8), 32'd0);
        if (q_deq_out) chk("deq_at_empty", 32'(q_len_in == 8'd0), 32'd0);
        if (re) begin
            sb.delete();
            for (int i = 0; i < preload_n; i++) sb.push_back(8'(8'hE0 + i));
        end else begin
            if (q_enq_out) sb.push_back(q_data_out);
            if (rd_valid_out) begin
                if (sb.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else chk("rd_order", 32'(rd_data_out), 32'(sb.pop_front()));
            end
        end
    endtask

    task automatic step();
        @(posedge clock_10);
        le = q_len_in;
        re = reset;
        @(negedge clock_10);
        mon();
    endtask

    task automatic do_reset(input int pre);
        preload_n = pre;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        do begin step(); n++; end while (!word_ack_out && n < budget);
        chk(tag, 32'(word_ack_out), 32'd1);
    endtask

    task automatic wait_rdv(input string tag, input int budget);
        int n = 0;
        do begin step(); n++; end while (!rd_valid_out && n < budget);
        chk(tag, 32'(rd_valid_out), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int acks;
        int nd;
        int ng;
        reset         = 1'b1;
        word_in       = 8'd0;
        word_valid_in = 1'b0;
        rd_req_in     = 1'b0;
        do_reset(0);
        chk("rst_rd_valid", 32'(rd_valid_out), 32'd0);
        chk("rst_rd_data", 32'(rd_data_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        chk("rst_enq", 32'(q_enq_out), 32'd0);
        chk("rst_deq", 32'(q_deq_out), 32'd0);

        // basic write then read
        word_in = 8'hA5;
        word_valid_in = 1'b1;
        step();
        chk("ack_pulse", 32'(word_ack_out), 32'd1);
        chk("enq_data", 32'(q_data_out), 32'hA5);
        word_valid_in = 1'b0;
        step();
        chk("ack_low", 32'(word_ack_out), 32'd0);
        chk("len_one", 32'(q_len_in), 32'd1);
        rd_req_in = 1'b1;
        step();
        chk("deq_strobe", 32'(q_deq_out), 32'd1);
        rd_req_in = 1'b0;
        step();
        chk("rd_valid_early", 32'(rd_valid_out), 32'd0);
        step();
        chk("rd_valid_k3", 32'(rd_valid_out), 32'd1);
        chk("rd_data_a5", 32'(rd_data_out), 32'hA5);
        step();
        chk("rd_valid_pulse", 32'(rd_valid_out), 32'd0);
        chk("empty_after", 32'(empty_out), 32'd1);

        // fill to full with valid held
        do_reset(0);
        word_in = 8'h01;
        word_valid_in = 1'b1;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (word_ack_out) begin
                acks++;
                if (word_in < 8'h09) word_in = word_in + 8'h01;
            end
        end
        chk("fill_acks", 32'(acks), 32'd8);
        chk("full_set", 32'(full_out), 32'd1);
        chk("len_full", 32'(q_len_in), 32'd8);
        rd_req_in = 1'b1;
        step();
        rd_req_in = 1'b0;
        chk("fill_deq", 32'(q_deq_out), 32'd1);
        wait_rdv("fill_rd_timeout", 6);
        chk("fill_rd_data", 32'(rd_data_out), 32'h01);
        wait_ack("ninth_ack_timeout", 10);
        chk("ninth_word", 32'(q_data_out), 32'h09);
        word_valid_in = 1'b0;

        // read while empty stays pending
        do_reset(0);
        rd_req_in = 1'b1;
        step();
        rd_req_in = 1'b0;
        nd = q_deq_out ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (q_deq_out) nd++;
        end
        chk("no_deq_empty", 32'(nd), 32'd0);
        word_in = 8'h3C;
        word_valid_in = 1'b1;
        wait_ack("empty_ack_timeout", 4);
        word_valid_in = 1'b0;
        wait_rdv("auto_rd_timeout", 8);
        chk("auto_read", 32'(rd_data_out), 32'h3C);

        // arbitration tie from a non-empty queue
        do_reset(3);
        word_in = 8'h50;
        word_valid_in = 1'b1;
        rd_req_in = 1'b1;
        ng = 0;
        for (int i = 0; i < 40 && ng < 8; i++) begin
            step();
            if (q_enq_out || q_deq_out) begin
                chk($sformatf("grant%0d", ng), 32'(q_deq_out), 32'(ng % 2));
                ng++;
            end
            if (word_ack_out) word_in = word_in + 8'h01;
        end
        chk("tie_grants", 32'(ng), 32'd8);
        word_valid_in = 1'b0;
        rd_req_in = 1'b0;

        // reset while in CAPT
        do_reset(0);
        word_in = 8'h77;
        word_valid_in = 1'b1;
        wait_ack("capt_ack_timeout", 4);
        word_valid_in = 1'b0;
        step();
        rd_req_in = 1'b1;
        step();
        chk("capt_deq", 32'(q_deq_out), 32'd1);
        step();
        chk("capt_no_deq", 32'(q_deq_out), 32'd0);
        rd_req_in = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("capt_rd_valid", 32'(rd_valid_out), 32'd0);
        chk("capt_rd_data", 32'(rd_data_out), 32'd0);
        chk("capt_empty", 32'(empty_out), 32'd1);
        word_in = 8'h11;
        word_valid_in = 1'b1;
        wait_ack("capt_ack2_timeout", 4);
        word_valid_in = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (q_deq_out) nd++;
        end
        chk("pending_cleared", 32'(nd), 32'd0);

        // inconsistent length
        do_reset(0);
        force_val = 8'd9;
        force_en = 1'b1;
        word_in = 8'h42;
        word_valid_in = 1'b1;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (q_enq_out) nd++;
        end
        chk("err_set", 32'(err_out), 32'd1);
        chk("no_enq_len9", 32'(nd), 32'd0);
        force_en = 1'b0;
        word_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", 32'(err_out), 32'd1);
        do_reset(0);
        chk("err_cleared", 32'(err_out), 32'd0);

        // random traffic against the scoreboard
        for (int i = 0; i < 800; i++) begin
            step();
            if (!word_valid_in || word_ack_out) begin
                word_valid_in = ($urandom_range(0, 2) != 0);
                word_in = 8'($urandom);
            end
            rd_req_in = ($urandom_range(0, 3) == 0);
        end
        word_valid_in = 1'b0;
        rd_req_in = 1'b1;
        for (int i = 0; i < 300 && q_len_in != 8'd0; i++) step();
        rd_req_in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("drain_len", 32'(q_len_in), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
